// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer (Moore FSM) with retire pulse and retired-instruction counter.
// Latency: lw 5 cycles; sw/R-type/addi 4; beq/j/jal 3. Outputs decode from state (pc_we also sees zero in BRANCH).
// No backpressure: advances one state per clock; rst aborts the instruction and gates all write enables.
module mc_ctrl #(
   parameter int CNT_W           = 32,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wd_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic [3:0]       state,
   output logic             retire,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXEC_R  = 4'd6;
   localparam logic [3:0] S_RWB     = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDI_EX = 4'd9;
   localparam logic [3:0] S_ADDI_WB = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
   localparam logic [3:0] S_JAL     = 4'd12;
   localparam logic [3:0] S_HALT    = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;
   logic             w_dec_illegal;
   logic             w_funct_ok;
   logic [2:0]       w_r_alu_op;
   logic             w_pc_we, w_mem_we, w_ir_we, w_reg_we, w_retire;

   // R-type funct decode: legality and the ALU operation it selects
   always_comb begin
      w_funct_ok = 1'b1;
      w_r_alu_op = ALU_ADD;
      case (funct)
         6'b100000: w_r_alu_op = ALU_ADD;
         6'b100010: w_r_alu_op = ALU_SUB;
         6'b100100: w_r_alu_op = ALU_AND;
         6'b100101: w_r_alu_op = ALU_OR;
         6'b101010: w_r_alu_op = ALU_SLT;
         default:   w_funct_ok = 1'b0;
      endcase
   end

   // Next-state logic; unknown instructions are caught only in DECODE
   always_comb begin
      w_next        = r_state;
      w_dec_illegal = 1'b0;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE: begin
                  if (w_funct_ok) w_next = S_EXEC_R;
                  else            w_dec_illegal = 1'b1;
               end
               OP_BEQ:  w_next = S_BRANCH;
               OP_ADDI: w_next = S_ADDI_EX;
               OP_J:    w_next = S_JUMP;
               OP_JAL:  w_next = S_JAL;
               default: w_dec_illegal = 1'b1;
            endcase
            if (w_dec_illegal) w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
         end
         S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = S_MEMWB;
         S_EXEC_R:  w_next = S_RWB;
         S_ADDI_EX: w_next = S_ADDI_WB;
         S_MEMWB, S_MEMWR, S_RWB, S_BRANCH,
         S_ADDI_WB, S_JUMP, S_JAL: w_next = S_FETCH;
         S_HALT:    w_next = S_HALT;
         default:   w_next = S_FETCH;   // unused encodings recover to fetch
      endcase
   end

   // Moore output decode (BRANCH additionally qualifies the PC write with zero)
   always_comb begin
      w_pc_we   = 1'b0;
      pc_src    = 2'd0;
      iord      = 1'b0;
      w_mem_we  = 1'b0;
      w_ir_we   = 1'b0;
      w_reg_we  = 1'b0;
      reg_dst   = 2'd0;
      wd_src    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = ALU_ADD;
      w_retire  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_we   = 1'b1;
            alu_src_b = 2'd1;
            w_pc_we   = 1'b1;
         end
         S_DECODE:  alu_src_b = 2'd3;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            w_reg_we = 1'b1;
            wd_src   = 2'd1;
            w_retire = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            w_mem_we = 1'b1;
            w_retire = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = w_r_alu_op;
         end
         S_RWB: begin
            w_reg_we = 1'b1;
            reg_dst  = 2'd1;
            w_retire = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'd1;
            w_pc_we   = zero;
            w_retire  = 1'b1;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_ADDI_WB: begin
            w_reg_we = 1'b1;
            w_retire = 1'b1;
         end
         S_JUMP: begin
            pc_src   = 2'd2;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
         end
         S_JAL: begin
            // r31 takes the current PC, already advanced to jal+4 in FETCH
            w_reg_we = 1'b1;
            reg_dst  = 2'd2;
            wd_src   = 2'd2;
            pc_src   = 2'd2;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
         end
         default: ;   // HALT and unused encodings: everything idle
      endcase
   end

   // Write enables are masked during reset so an aborted instruction never commits
   assign pc_we   = w_pc_we  & ~rst;
   assign mem_we  = w_mem_we & ~rst;
   assign ir_we   = w_ir_we  & ~rst;
   assign reg_we  = w_reg_we & ~rst;
   assign retire  = w_retire & ~rst;
   assign state   = r_state;
   assign illegal = r_illegal;
   assign retired = r_retired;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // Sticky illegal-instruction flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      r_illegal <= 1'b0;
      else if (r_state == S_DECODE && w_dec_illegal) r_illegal <= 1'b1;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + CNT_W'(1);
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table plus illegal/halt, reset-abort and counter-wrap sequences.
// Outputs sampled on the falling edge; inputs change just after the rising edge.
// Second instance with CNT_W=4 runs a stream of j instructions to exercise wrap.
module tb_mc_ctrl;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] JAL  = 6'b000011;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero;
   logic        pc_we, iord, mem_we, ir_we, reg_we, alu_src_a, retire, illegal;
   logic [1:0]  pc_src, reg_dst, wd_src, alu_src_b;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        rst4;
   logic        pc_we4, iord4, mem_we4, ir_we4, reg_we4, alu_src_a4, retire4, illegal4;
   logic [1:0]  pc_src4, reg_dst4, wd_src4, alu_src_b4;
   logic [2:0]  alu_op4;
   logic [3:0]  state4;
   logic [3:0]  retired4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .mem_we(mem_we), .ir_we(ir_we),
      .reg_we(reg_we), .reg_dst(reg_dst), .wd_src(wd_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .retire(retire),
      .illegal(illegal), .retired(retired)
   );

   mc_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst4), .opcode(JMP), .funct(6'd0), .zero(1'b0),
      .pc_we(pc_we4), .pc_src(pc_src4), .iord(iord4), .mem_we(mem_we4), .ir_we(ir_we4),
      .reg_we(reg_we4), .reg_dst(reg_dst4), .wd_src(wd_src4), .alu_src_a(alu_src_a4),
      .alu_src_b(alu_src_b4), .alu_op(alu_op4), .state(state4), .retire(retire4),
      .illegal(illegal4), .retired(retired4)
   );

   typedef struct {
      int op, fn, z;
      int st, pcwe, pcsrc, iord, mwe, irwe, rwe, dst, wd, a, b, aop, ret, cnt;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // one cycle row: inputs, state, pc_we pc_src iord mem_we ir_we reg_we reg_dst wd_src a b alu_op retire retired
   task automatic add(input int op, input int fn, input int z, input int st,
                      input int pcwe, input int pcsrc, input int io, input int mwe,
                      input int irwe, input int rwe, input int dst, input int wd,
                      input int a, input int b, input int aop, input int ret, input int cnt);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.st = st; v.pcwe = pcwe; v.pcsrc = pcsrc;
      v.iord = io; v.mwe = mwe; v.irwe = irwe; v.rwe = rwe; v.dst = dst; v.wd = wd;
      v.a = a; v.b = b; v.aop = aop; v.ret = ret; v.cnt = cnt;
      vq.push_back(v);
   endtask

   // FETCH and DECODE rows, identical for every instruction
   task automatic add_fd(input int op, input int fn, input int z, input int cnt);
      add(op, fn, z, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, cnt);
      add(op, fn, z, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, cnt);
   endtask

   initial begin
      rst = 1'b1; rst4 = 1'b1;
      opcode = LW; funct = 6'd0; zero = 1'b0;

      // ---- table: one row per clock cycle ----
      add_fd(LW, 0, 0, 0);
      add(LW, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      add(LW, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(LW, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
      add_fd(BEQ, 0, 1, 1);
      add(BEQ, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
      add_fd(BEQ, 0, 0, 2);
      add(BEQ, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2);
      add_fd(JAL, 0, 0, 3);
      add(JAL, 0, 0, 12, 1, 2, 0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 3);
      for (int k = 0; k < 5; k++) begin
         int fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
         add_fd(RT, fns[k], 0, 4 + k);
         add(RT, fns[k], 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, k, 0, 4 + k);
         add(RT, fns[k], 0, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 4 + k);
      end
      add_fd(ADDI, 0, 0, 9);
      add(ADDI, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 9);
      add(ADDI, 0, 0, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 9);
      add_fd(SW, 0, 0, 10);
      add(SW, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 10);
      add(SW, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 10);
      add_fd(JMP, 0, 0, 11);
      add(JMP, 0, 0, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11);

      // ---- reset state (t=10, rst still high) ----
      #10;
      chk("rst_state", int'(state), 0);
      chk("rst_pc_we", int'(pc_we), 0);
      chk("rst_ir_we", int'(ir_we), 0);
      chk("rst_retire", int'(retire), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_retired", int'(retired), 0);
      #8 rst = 1'b0;   // released at 18 ns

      // ---- apply table ----
      foreach (vq[i]) begin
         opcode = 6'(vq[i].op);
         funct  = 6'(vq[i].fn);
         zero   = vq[i].z[0];
         @(negedge clk);
         chk($sformatf("v%0d state", i),   int'(state),     vq[i].st);
         chk($sformatf("v%0d pc_we", i),   int'(pc_we),     vq[i].pcwe);
         chk($sformatf("v%0d pc_src", i),  int'(pc_src),    vq[i].pcsrc);
         chk($sformatf("v%0d iord", i),    int'(iord),      vq[i].iord);
         chk($sformatf("v%0d mem_we", i),  int'(mem_we),    vq[i].mwe);
         chk($sformatf("v%0d ir_we", i),   int'(ir_we),     vq[i].irwe);
         chk($sformatf("v%0d reg_we", i),  int'(reg_we),    vq[i].rwe);
         chk($sformatf("v%0d reg_dst", i), int'(reg_dst),   vq[i].dst);
         chk($sformatf("v%0d wd_src", i),  int'(wd_src),    vq[i].wd);
         chk($sformatf("v%0d src_a", i),   int'(alu_src_a), vq[i].a);
         chk($sformatf("v%0d src_b", i),   int'(alu_src_b), vq[i].b);
         chk($sformatf("v%0d alu_op", i),  int'(alu_op),    vq[i].aop);
         chk($sformatf("v%0d retire", i),  int'(retire),    vq[i].ret);
         chk($sformatf("v%0d retired", i), int'(retired),   vq[i].cnt);
         @(posedge clk); #1;
      end
      chk("retired_after_table", int'(retired), 12);
      chk("illegal_after_table", int'(illegal), 0);

      // ---- illegal opcode parks in HALT ----
      opcode = 6'b111111;
      @(negedge clk);
      chk("ill_fetch_state", int'(state), 0);
      @(posedge clk); #1;
      chk("ill_decode_state", int'(state), 1);
      chk("ill_decode_flag", int'(illegal), 0);
      @(posedge clk); #1;
      chk("ill_halt_state", int'(state), 15);
      chk("ill_flag_set", int'(illegal), 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("halt_stays", int'(state), 15);
      chk("halt_flag_sticky", int'(illegal), 1);
      chk("halt_enables", int'({pc_we, ir_we, reg_we, mem_we, retire}), 0);
      chk("halt_retired", int'(retired), 12);

      // ---- asynchronous reset clears HALT and the flag ----
      #1 rst = 1'b1;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_illegal", int'(illegal), 0);
      chk("arst_retired", int'(retired), 0);
      @(posedge clk); #2 rst = 1'b0;

      // ---- sw aborted by reset in MEMWR ----
      opcode = SW;
      @(posedge clk); #1;
      chk("sw_decode", int'(state), 1);
      @(posedge clk); #1;
      chk("sw_memadr", int'(state), 2);
      @(posedge clk); #1;
      chk("sw_memwr", int'(state), 5);
      chk("sw_mem_we_on", int'(mem_we), 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_we", int'(mem_we), 0);
      chk("abort_retire", int'(retire), 0);
      chk("abort_state", int'(state), 0);
      chk("abort_retired", int'(retired), 0);
      @(posedge clk); #1;
      chk("abort_hold_mem_we", int'(mem_we), 0);
      chk("abort_hold_retired", int'(retired), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rel_state", int'(state), 0);
      chk("post_rel_ir_we", int'(ir_we), 1);
      @(posedge clk); #1;
      chk("post_rel_decode", int'(state), 1);

      // ---- CNT_W=4 wrap: 17 j instructions in 51 cycles ----
      rst4 = 1'b0;
      repeat (47) @(posedge clk);
      #1;
      chk("w4_15_retired", int'(retired4), 15);
      chk("w4_jump_state", int'(state4), 11);
      chk("w4_jump_retire", int'(retire4), 1);
      @(posedge clk); #1;
      chk("w4_wrap_zero", int'(retired4), 0);
      chk("w4_fetch_state", int'(state4), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("w4_51cyc_retired", int'(retired4), 1);
      chk("w4_51cyc_state", int'(state4), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
